// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - triggered pin capture with a stream output FIFO
//
// Samples the pin input bus and tri-state enables, waits for a masked
// trigger match, then records num_samples samples into an output FIFO
// that is drained over a valid/ready stream.
//
// Optional build macro: TRACE_CAPTURE_TIMESTAMP_EN adds a 16-bit cycle
// timestamp in the top bits of every stream word.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start, abort        one-cycle control pulses (abort wins)
//   sample_en           sample strobe; samples are taken only when 1
//   num_samples         capture length (0 behaves as 1), latched on start
//   trig_mask/value     trigger compare, latched on start
//   pin_data_i/tri_i    pin levels and tri-state enables
//   m_tdata/tvalid/tlast/tready  output sample stream
//   busy, done          status (ARMED/CAPTURE, DONE)
//   overflow            sticky: a sample was dropped on a full FIFO
module trace_capture #(
  parameter int PIN_W      = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16,
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  localparam int TDW       = 2*PIN_W + 16
`else
  localparam int TDW       = 2*PIN_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [PIN_W-1:0] trig_mask,
  input  logic [PIN_W-1:0] trig_value,
  input  logic [PIN_W-1:0] pin_data_i,
  input  logic [PIN_W-1:0] pin_tri_i,
  output logic [TDW-1:0]   m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t state, state_nx;

  logic [PIN_W-1:0] pin_data_r, pin_tri_r;
  logic             en_r;
  logic [TDW-1:0]   cmp_sample;
  logic             cmp_match, cmp_en;

  logic [CNT_W-1:0] cnt, nsamp_r, nsamp_eff, cnt_plus;
  logic [PIN_W-1:0] mask_r, value_r;

  logic             start_acc;
  logic             push_due, push_last, push_ok, cnt_inc, pop;

  logic [TDW-1:0]   mem [FIFO_DEPTH];
  logic             last_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_prev, count;
  logic             full, empty;

  assign start_acc = start && !abort && (state == S_IDLE || state == S_DONE);

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts, ts_r;

  always_ff @(posedge clk) begin
    if (reset || start_acc) ts <= '0;
    else                    ts <= ts + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) ts_r <= '0;
    else       ts_r <= ts;
  end
`endif

  // Input register followed by the compare register. The strobe travels
  // with its pins, and both stages are flushed on start so a capture only
  // ever sees samples taken after the start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_data_r <= '0;
      pin_tri_r  <= '0;
      en_r       <= 1'b0;
      cmp_sample <= '0;
      cmp_match  <= 1'b0;
      cmp_en     <= 1'b0;
    end else begin
      pin_data_r <= pin_data_i;
      pin_tri_r  <= pin_tri_i;
      en_r       <= sample_en && !start_acc;
      cmp_en     <= en_r && !start_acc;
      cmp_match  <= ((pin_data_r ^ value_r) & mask_r) == '0;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
      cmp_sample <= {ts_r, pin_tri_r, pin_data_r};
`else
      cmp_sample <= {pin_tri_r, pin_data_r};
`endif
    end
  end

  assign nsamp_eff = (nsamp_r == '0) ? CNT_W'(1) : nsamp_r;
  assign cnt_plus  = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // The counter is zero when ARMED, so the triggering sample naturally
  // becomes sample 1 through the same compare used during CAPTURE.
  always_comb begin
    state_nx  = state;
    push_due  = 1'b0;
    push_last = 1'b0;
    cnt_inc   = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) state_nx = S_ARMED;
        end
        S_ARMED, S_CAPTURE: begin
          if (cmp_en && (state == S_CAPTURE || cmp_match)) begin
            push_due = 1'b1;
            cnt_inc  = 1'b1;
            state_nx = S_CAPTURE;
            if (cnt_plus == nsamp_eff) begin
              push_last = 1'b1;
              state_nx  = S_DONE;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      nsamp_r  <= '0;
      mask_r   <= '0;
      value_r  <= '0;
      overflow <= 1'b0;
    end else if (start_acc) begin
      cnt      <= '0;
      nsamp_r  <= num_samples;
      mask_r   <= trig_mask;
      value_r  <= trig_value;
      overflow <= 1'b0;
    end else begin
      if (cnt_inc) cnt <= cnt_plus;
      // Dropped samples still count so the capture length is fixed.
      if (push_due && !push_ok) overflow <= 1'b1;
    end
  end

  // Output FIFO. A pop in the same cycle frees a slot for a push on full.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = m_tvalid && m_tready;
  assign push_ok = push_due && (!full || pop);
  assign wr_prev = wr_ptr - PW'(1);

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // When the final sample is dropped, the newest stored entry takes the
  // last flag so the stream still terminates. A drop implies a full FIFO
  // with no pop, so that entry is never the one currently presented.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]]      <= cmp_sample;
      last_mem[wr_ptr[AW-1:0]] <= push_last;
    end else if (push_due && push_last && !empty) begin
      last_mem[wr_prev[AW-1:0]] <= 1'b1;
    end
  end

  assign m_tvalid = !empty;
  assign m_tdata  = m_tvalid ? mem[rd_ptr[AW-1:0]] : '0;
  assign m_tlast  = m_tvalid && last_mem[rd_ptr[AW-1:0]];
  assign busy     = (state == S_ARMED) || (state == S_CAPTURE);
  assign done     = (state == S_DONE);

endmodule
